// File: rtl/hack_pkg.sv
// hack_pkg: shared types and constants for the Hack CPU controller.
// Holds the controller state encoding, instruction field positions and
// the comp/dest/jump opcode constants used to build instruction words.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEMRD  = 3'd2,
    EXEC   = 3'd3,
    MEMWR  = 3'd4
  } state_t;

  // Instruction field positions
  localparam int unsigned CI_BIT     = 15;
  localparam int unsigned A_BIT      = 12;
  localparam int unsigned CTRL_HI    = 11;
  localparam int unsigned CTRL_LO    = 6;
  localparam int unsigned DEST_HI    = 5;
  localparam int unsigned DEST_LO    = 3;
  localparam int unsigned JMP_HI     = 2;
  localparam int unsigned JMP_LO     = 0;
  localparam int unsigned DEST_A_BIT = 5;
  localparam int unsigned DEST_D_BIT = 4;
  localparam int unsigned DEST_M_BIT = 3;

  // comp field (zx nx zy ny f no); Y is A when a=0, M when a=1
  localparam logic [5:0] COMP_ZERO    = 6'b101010;
  localparam logic [5:0] COMP_ONE     = 6'b111111;
  localparam logic [5:0] COMP_NEG1    = 6'b111010;
  localparam logic [5:0] COMP_D       = 6'b001100;
  localparam logic [5:0] COMP_Y       = 6'b110000;
  localparam logic [5:0] COMP_NOT_D   = 6'b001101;
  localparam logic [5:0] COMP_NOT_Y   = 6'b110001;
  localparam logic [5:0] COMP_NEG_D   = 6'b001111;
  localparam logic [5:0] COMP_NEG_Y   = 6'b110011;
  localparam logic [5:0] COMP_D_INC   = 6'b011111;
  localparam logic [5:0] COMP_Y_INC   = 6'b110111;
  localparam logic [5:0] COMP_D_DEC   = 6'b001110;
  localparam logic [5:0] COMP_Y_DEC   = 6'b110010;
  localparam logic [5:0] COMP_D_ADD_Y = 6'b000010;
  localparam logic [5:0] COMP_D_SUB_Y = 6'b010011;
  localparam logic [5:0] COMP_Y_SUB_D = 6'b000111;
  localparam logic [5:0] COMP_D_AND_Y = 6'b000000;
  localparam logic [5:0] COMP_D_OR_Y  = 6'b010101;

  // dest field (A D M)
  localparam logic [2:0] DEST_NULL = 3'b000;
  localparam logic [2:0] DEST_M    = 3'b001;
  localparam logic [2:0] DEST_D    = 3'b010;
  localparam logic [2:0] DEST_MD   = 3'b011;
  localparam logic [2:0] DEST_A    = 3'b100;
  localparam logic [2:0] DEST_AM   = 3'b101;
  localparam logic [2:0] DEST_AD   = 3'b110;
  localparam logic [2:0] DEST_AMD  = 3'b111;

  // jump field (lt eq gt)
  localparam logic [2:0] JMP_NULL = 3'b000;
  localparam logic [2:0] JMP_JGT  = 3'b001;
  localparam logic [2:0] JMP_JEQ  = 3'b010;
  localparam logic [2:0] JMP_JGE  = 3'b011;
  localparam logic [2:0] JMP_JLT  = 3'b100;
  localparam logic [2:0] JMP_JNE  = 3'b101;
  localparam logic [2:0] JMP_JLE  = 3'b110;
  localparam logic [2:0] JMP_JMP  = 3'b111;

  // Assemble a C-instruction word; bits 14:13 are set to 1 by convention
  function automatic logic [15:0] c_instr(input logic a, input logic [5:0] comp,
                                          input logic [2:0] dest, input logic [2:0] jmp);
    return {3'b111, a, comp, dest, jmp};
  endfunction

endpackage

// File: rtl/hack_jump_unit.sv
// hack_jump_unit: resolves the Hack jump condition from the j bits and ALU flags.
module hack_jump_unit (
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // j1 = negative, j2 = zero, j3 = strictly positive
  always_comb begin
    take = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~zr & ~ng);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU control/datapath around an external ALU.
// Fetches over a req/ack instruction port, sequences data-memory reads and
// writes, owns A/D/PC and resolves jumps.
// Optional: define HACK_CTRL_RETIRE_CNT_EN to add the retire_cnt output.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned     PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_ack,
  input  logic [15:0]     instr_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [15:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            alu_zx,
  output logic            alu_nx,
  output logic            alu_zy,
  output logic            alu_ny,
  output logic            alu_f,
  output logic            alu_no,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng
`ifdef HACK_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0]     retire_cnt
`endif
);

  state_t          state;
  state_t          state_next;
  logic [15:0]     ir;
  logic [15:0]     a_reg;
  logic [15:0]     d_reg;
  logic [15:0]     m_latch;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            instr_fire;
  logic            mem_fire;
  logic            is_c;
  logic            use_m;
  logic            dest_a;
  logic            dest_d;
  logic            dest_m;
  logic            take;

  hack_jump_unit u_jump (
    .jmp  (ir[JMP_HI:JMP_LO]),
    .zr   (alu_zr),
    .ng   (alu_ng),
    .take (take)
  );

  // Handshake qualifiers and instruction field decode
  always_comb begin
    instr_fire = instr_req & instr_ack;
    mem_fire   = mem_req & mem_ack;
    is_c       = ir[CI_BIT];
    use_m      = ir[A_BIT];
    dest_a     = ir[DEST_A_BIT];
    dest_d     = ir[DEST_D_BIT];
    dest_m     = ir[DEST_M_BIT];
    pc_inc     = pc + 1'b1;
  end

  // Datapath-facing outputs: ALU operands and control bits straight from IR
  always_comb begin
    instr_addr = pc;
    alu_x      = d_reg;
    alu_y      = use_m ? m_latch : a_reg;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[CTRL_HI:CTRL_LO];
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:  if (instr_fire) state_next = DECODE;
      DECODE: begin
        if (!is_c)      state_next = FETCH;
        else if (use_m) state_next = MEMRD;
        else            state_next = EXEC;
      end
      MEMRD:  if (mem_fire) state_next = EXEC;
      EXEC:   state_next = dest_m ? MEMWR : FETCH;
      MEMWR:  if (mem_fire) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // State and request registers; requests are derived from the state being
  // entered so they are high from the first cycle of FETCH/MEMRD/MEMWR
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      instr_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_next;
      instr_req <= (state_next == FETCH);
      mem_req   <= (state_next == MEMRD) || (state_next == MEMWR);
      mem_we    <= (state_next == MEMWR);
    end
  end

  // Architectural registers, latches and program counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      a_reg     <= '0;
      d_reg     <= '0;
      m_latch   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        FETCH: if (instr_fire) ir <= instr_rdata;
        DECODE: begin
          // A is stable from DECODE through EXEC for a C-instruction, so this
          // snapshot is the pre-EXEC A used by both MEMRD and MEMWR
          mem_addr <= a_reg[PC_W-1:0];
          if (!is_c) begin
            a_reg <= {1'b0, ir[14:0]};
            pc    <= pc_inc;
          end
        end
        MEMRD: if (mem_fire) m_latch <= mem_rdata;
        EXEC: begin
          mem_wdata <= alu_out;
          if (dest_a) a_reg <= alu_out;
          if (dest_d) d_reg <= alu_out;
          pc <= take ? a_reg[PC_W-1:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef HACK_CTRL_RETIRE_CNT_EN
  logic retire_evt;

  // An instruction completes in DECODE (A), EXEC without M store, or MEMWR ack
  always_comb begin
    retire_evt = ((state == DECODE) && !is_c) ||
                 ((state == EXEC) && !dest_m) ||
                 ((state == MEMWR) && mem_fire);
  end

  // Free-running retired-instruction counter, wraps at 2^32
  always_ff @(posedge clk) begin
    if (rst)             retire_cnt <= '0;
    else if (retire_evt) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: self-checking bench for hack_cpu_ctrl with memory
// responders, a Hack ALU, and an instruction-level reference model.
`timescale 1ns/1ps
module tb_hack_cpu_ctrl;
  import hack_pkg::*;

  localparam int unsigned PC_W = 15;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
  } mem_op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req, instr_ack;
  logic [14:0] instr_addr;
  logic [15:0] instr_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
`ifdef HACK_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  hack_cpu_ctrl #(.PC_W(PC_W), .RESET_PC(15'h0000)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .instr_rdata(instr_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
`ifdef HACK_CTRL_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Hack ALU attached to the DUT
  logic [15:0] ax, ay;
  always_comb begin
    ax = alu_zx ? 16'h0000 : alu_x;
    if (alu_nx) ax = ~ax;
    ay = alu_zy ? 16'h0000 : alu_y;
    if (alu_ny) ay = ~ay;
    alu_out = alu_f ? (ax + ay) : (ax & ay);
    if (alu_no) alu_out = ~alu_out;
    alu_zr = (alu_out == 16'h0000);
    alu_ng = alu_out[15];
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];
  logic [5:0]  comp_tab [18];

  // Reference model state (instruction level)
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  mem_op_t     exp_q[$];
  logic [14:0] fetch_log[$];
  mem_op_t     wr_log[$];
  int          retired, fetches, cyc, next_fetch_cyc;
  bit          lat_valid;

  // Responder configuration; a negative fixed wait means random up to *_max
  int          iw_fix, mw_rd_fix, mw_wr_fix;
  int unsigned iw_max, mw_max;
  bit          stray_en;
  int unsigned i_cnt, i_wait, m_cnt, m_wait;
  logic [14:0] i_addr_s, m_addr_s;
  logic        m_we_s;
  logic [15:0] m_wd_s;

  function automatic logic [15:0] ref_comp(input logic [5:0] c, input logic [15:0] d,
                                           input logic [15:0] y);
    case (c)
      COMP_ZERO:    return 16'h0000;
      COMP_ONE:     return 16'h0001;
      COMP_NEG1:    return 16'hFFFF;
      COMP_D:       return d;
      COMP_Y:       return y;
      COMP_NOT_D:   return ~d;
      COMP_NOT_Y:   return ~y;
      COMP_NEG_D:   return 16'h0000 - d;
      COMP_NEG_Y:   return 16'h0000 - y;
      COMP_D_INC:   return d + 16'd1;
      COMP_Y_INC:   return y + 16'd1;
      COMP_D_DEC:   return d - 16'd1;
      COMP_Y_DEC:   return y - 16'd1;
      COMP_D_ADD_Y: return d + y;
      COMP_D_SUB_Y: return d - y;
      COMP_Y_SUB_D: return y - d;
      COMP_D_AND_Y: return d & y;
      COMP_D_OR_Y:  return d | y;
      default:      return 16'hxxxx;
    endcase
  endfunction

  function automatic int unsigned pick(input int fix, input int unsigned mx);
    if (fix >= 0) return int'(fix);
    return $urandom_range(mx, 0);
  endfunction

  task automatic model_reset();
    m_a = '0; m_d = '0; m_pc = '0;
    exp_q.delete(); fetch_log.delete(); wr_log.delete();
    retired = 0; fetches = 0; lat_valid = 0;
  endtask

  // Called when an instruction handshake is about to complete
  task automatic on_fetch(input logic [14:0] addr, input logic [15:0] w);
    logic        a, take;
    logic [2:0]  dst, j;
    logic [15:0] y, res;
    int          rest;
    check("fetch_pc", 32'(addr), 32'(m_pc));
    check("fetch_mem_idle", exp_q.size(), 0);
`ifdef HACK_CTRL_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, retired);
`endif
    if (lat_valid) check("latency", cyc, next_fetch_cyc + int'(i_wait));
    fetch_log.push_back(addr);
    if (!w[15]) begin
      m_a  = w;
      m_pc = m_pc + 15'd1;
      rest = 1;
    end else begin
      a   = w[12];
      dst = w[5:3];
      j   = w[2:0];
      y   = a ? ram[m_a[14:0]] : m_a;
      res = ref_comp(w[11:6], m_d, y);
      if (a) exp_q.push_back('{we: 1'b0, addr: m_a[14:0], data: 16'h0000});
      if (dst[0]) exp_q.push_back('{we: 1'b1, addr: m_a[14:0], data: res});
      take = (j[2] && ($signed(res) < 0)) || (j[1] && (res == 16'h0000)) ||
             (j[0] && ($signed(res) > 0));
      m_pc = take ? m_a[14:0] : m_pc + 15'd1;
      if (dst[2]) m_a = res;
      if (dst[1]) m_d = res;
      rest = 2;
      if (a) rest++;
      if (dst[0]) rest++;
    end
    next_fetch_cyc = cyc + rest + 1;
    lat_valid = 1;
    retired++;
    fetches++;
  endtask

  // Called when a data handshake is about to complete
  task automatic on_mem();
    mem_op_t op;
    check("mem_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      op = exp_q.pop_front();
      check("mem_we", 32'(mem_we), 32'(op.we));
      check("mem_addr", 32'(mem_addr), 32'(op.addr));
      if (op.we) check("mem_wdata", 32'(mem_wdata), 32'(op.data));
    end
    next_fetch_cyc = next_fetch_cyc + int'(m_wait);
    if (mem_we) begin
      ram[mem_addr] = mem_wdata;
      wr_log.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
    end else begin
      mem_rdata = ram[mem_addr];
    end
  endtask

  // Memory responders: decide acks at negedge for the following posedge
  initial begin
    instr_ack = 0; instr_rdata = '0; mem_ack = 0; mem_rdata = '0;
    cyc = 0; i_cnt = 0; m_cnt = 0; i_wait = 0; m_wait = 0;
    forever begin
      @(negedge clk);
      cyc++;
      instr_ack = 0; mem_ack = 0;
      instr_rdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      if (rst) begin
        model_reset();
        i_cnt = 0; m_cnt = 0;
      end else begin
        if (instr_req) begin
          if (i_cnt == 0) begin
            i_wait = pick(iw_fix, iw_max);
            i_addr_s = instr_addr;
          end else begin
            check("instr_addr_stable", 32'(instr_addr), 32'(i_addr_s));
          end
          if (i_cnt == i_wait) begin
            instr_ack = 1;
            instr_rdata = rom[instr_addr];
            i_cnt = 0;
            on_fetch(instr_addr, instr_rdata);
          end else i_cnt++;
        end else if (stray_en) instr_ack = 1'($urandom);
        if (mem_req) begin
          if (m_cnt == 0) begin
            m_wait = pick(mem_we ? mw_wr_fix : mw_rd_fix, mw_max);
            m_addr_s = mem_addr; m_we_s = mem_we; m_wd_s = mem_wdata;
          end else begin
            check("mem_addr_stable", 32'(mem_addr), 32'(m_addr_s));
            check("mem_we_stable", 32'(mem_we), 32'(m_we_s));
            if (m_we_s) check("mem_wdata_stable", 32'(mem_wdata), 32'(m_wd_s));
          end
          if (m_cnt == m_wait) begin
            mem_ack = 1;
            m_cnt = 0;
            on_mem();
          end else m_cnt++;
        end else if (stray_en) mem_ack = 1'($urandom);
      end
    end
  end

  task automatic wait_fetches(input string tag, input int n, input int budget);
    int c = 0;
    while (fetches < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(fetches >= n), 1);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_instr_req", 32'(instr_req), 0);
      check("rst_mem_req", 32'(mem_req), 0);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ram32;
    logic [14:0] exp_pcs [18];
    comp_tab = '{COMP_ZERO, COMP_ONE, COMP_NEG1, COMP_D, COMP_Y, COMP_NOT_D,
                 COMP_NOT_Y, COMP_NEG_D, COMP_NEG_Y, COMP_D_INC, COMP_Y_INC,
                 COMP_D_DEC, COMP_Y_DEC, COMP_D_ADD_Y, COMP_D_SUB_Y,
                 COMP_Y_SUB_D, COMP_D_AND_Y, COMP_D_OR_Y};
    exp_pcs = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8,
                15'd16, 15'd17, 15'd18, 15'd19, 15'd32, 15'd33, 15'd34,
                15'h7FFF, 15'd0};
    iw_fix = 0; mw_rd_fix = 0; mw_wr_fix = 2; iw_max = 0; mw_max = 0; stray_en = 0;

    // Directed program: A-load, D=A, M=D with wait states, JEQ taken/not, JMP,
    // M=M+1, then PC wrap from 0x7FFF
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'($urandom);
    end
    rom[0]  = 16'h0005;  rom[1]  = 16'hEC10;
    rom[2]  = 16'h0007;  rom[3]  = 16'hEC10;
    rom[4]  = 16'h0064;  rom[5]  = 16'hE308;
    rom[6]  = 16'hEA90;  rom[7]  = 16'h0010;  rom[8] = 16'hE302;
    rom[16] = 16'hEFD0;  rom[17] = 16'h0020;  rom[18] = 16'hE302;
    rom[19] = 16'hE307;
    rom[32] = c_instr(1'b1, COMP_Y_INC, DEST_M, JMP_NULL);
    rom[33] = 16'h7FFF;  rom[34] = 16'hE307;
    rom[32767] = 16'hEC10;
    ram32 = ram[32];

    @(negedge clk);
    check("rst_instr_addr", 32'(instr_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 0);
    check("rst_alu_x", 32'(alu_x), 0);
    check("rst_alu_y", 32'(alu_y), 0);
`ifdef HACK_CTRL_RETIRE_CNT_EN
    check("rst_retire_cnt", retire_cnt, 0);
`endif
    apply_reset(2);
    wait_fetches("directed_done", 18, 400);
    check("directed_nfetch", fetch_log.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < fetch_log.size()) check("directed_pc_seq", 32'(fetch_log[i]), 32'(exp_pcs[i]));
    check("directed_nwrites", wr_log.size(), 2);
    if (wr_log.size() >= 2) begin
      check("wr0_addr", 32'(wr_log[0].addr), 100);
      check("wr0_data", 32'(wr_log[0].data), 7);
      check("wr1_addr", 32'(wr_log[1].addr), 32);
      check("wr1_data", 32'(wr_log[1].data), 32'(ram32 + 16'd1));
    end

    // Reset while MEMRD is stalled with mem_ack low
    rom[0] = 16'h0003;
    rom[1] = c_instr(1'b1, COMP_Y, DEST_D, JMP_NULL);
    rom[2] = c_instr(1'b0, COMP_D, DEST_M, JMP_NULL);
    mw_rd_fix = 1000; mw_wr_fix = 0;
    apply_reset(2);
    begin
      int c = 0;
      while (!mem_req && c < 20) begin @(negedge clk); c++; end
    end
    repeat (3) @(negedge clk);
    check("memrd_stalled_req", 32'(mem_req), 1);
    check("memrd_stalled_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    check("abort_mem_req", 32'(mem_req), 0);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_instr_req", 32'(instr_req), 0);
    check("abort_pc", 32'(instr_addr), 0);
    check("abort_alu_x", 32'(alu_x), 0);
`ifdef HACK_CTRL_RETIRE_CNT_EN
    check("abort_retire_cnt", retire_cnt, 0);
`endif
    mw_rd_fix = 0; stray_en = 1;
    rst = 0;
    wait_fetches("after_abort", 4, 200);
    if (fetch_log.size() >= 2) begin
      check("after_abort_pc0", 32'(fetch_log[0]), 0);
      check("after_abort_pc1", 32'(fetch_log[1]), 1);
    end

    // Randomized program with random wait states and stray acks
    for (int i = 0; i < 32768; i++) begin
      if ($urandom_range(99, 0) < 45) begin
        if ($urandom_range(1, 0) == 1) rom[i] = 16'($urandom_range(15, 0));
        else rom[i] = {1'b0, 15'($urandom)};
      end else begin
        rom[i] = {1'b1, 2'($urandom), 1'($urandom), comp_tab[$urandom_range(17, 0)],
                  3'($urandom), 3'($urandom)};
      end
      ram[i] = 16'($urandom);
    end
    iw_fix = -1; mw_rd_fix = -1; mw_wr_fix = -1; iw_max = 2; mw_max = 2;
    apply_reset(2);
    wait_fetches("random_done", 1500, 40000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
